// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the sequential ALU.
//   - Op-code localparams (encoding kept from the combinational MIPS ALU).
//   - FSM state encoding for alu_seq.
package alu_pkg;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_AND = 4'b0100;
  localparam logic [3:0] OP_OR  = 4'b0101;
  localparam logic [3:0] OP_SLL = 4'b0110;
  localparam logic [3:0] OP_SRL = 4'b0111;
  localparam logic [3:0] OP_SLT = 4'b1000;
  localparam logic [3:0] OP_BEQ = 4'b1001;
  localparam logic [3:0] OP_BNE = 4'b1010;
  localparam logic [3:0] OP_MUL = 4'b1011;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_MUL   = 2'd1,
    S_VALID = 2'd2
  } state_t;

endpackage

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: iterative unsigned shift-add multiplier.
// Takes exactly WIDTH cycles after start. done is asserted combinationally during the
// last iteration cycle, with product already holding the final value, so the caller can
// register the result on the same edge that retires the last iteration.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   start         load operands a/b and begin (ignored while busy)
//   a, b          WIDTH-bit unsigned operands
//   busy          iteration in progress
//   done          final iteration in progress this cycle
//   product       2*WIDTH-bit product (valid when done)
module alu_mul_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int unsigned CW = $clog2(WIDTH);

  logic [CW-1:0]      cnt;
  logic               run;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0]   mplier;

  always_comb begin
    acc_nxt = acc + (mplier[0] ? mcand : '0);
    done    = run && (cnt == CW'(WIDTH - 1));
    product = acc_nxt;
    busy    = run;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      run    <= 1'b0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else if (start && !run) begin
      cnt    <= '0;
      run    <= 1'b1;
      acc    <= '0;
      mcand  <= {{WIDTH{1'b0}}, a};
      mplier <= b;
    end else if (run) begin
      acc    <= acc_nxt;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
      if (done) begin
        run <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: registered, valid/ready handshaked MIPS ALU with parametrised width.
// Optional feature macro: ALU_MUL_EN enables the iterative MUL (op 1011); when undefined,
// 1011 is an unused encoding (result 0, overflow 0, single-cycle) and busy is tied 0.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   in_valid / in_ready   input handshake
//   aluSrc                0: operand B = data2, 1: operand B = imm
//   data1, data2, imm     operands (imm already extended)
//   aluCtrl               operation select
//   out_valid / out_ready output handshake
//   result, zero, overflow registered result and flags
//   busy                  multiply iteration in progress
module alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             aluSrc,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  input  logic [WIDTH-1:0] imm,
  input  logic [3:0]       aluCtrl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             busy
);

  localparam int unsigned SHW = $clog2(WIDTH);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH:0]   add_w;
  logic [WIDTH:0]   sub_w;
  logic [WIDTH-1:0] alu_res;
  logic             alu_ovf;
  logic             accept;
  logic             is_mul;
  logic             load;
  logic [WIDTH-1:0] res_nxt;
  logic             ovf_nxt;
  logic             mul_done;
  logic [2*WIDTH-1:0] mul_prod;

  // Single-cycle datapath.
  always_comb begin
    op_b    = aluSrc ? imm : data2;
    // One extra bit captures carry (ADD) or borrow (SUB).
    add_w   = {1'b0, data1} + {1'b0, op_b};
    sub_w   = {1'b0, data1} - {1'b0, op_b};
    alu_res = '0;
    alu_ovf = 1'b0;
    case (aluCtrl)
      OP_ADD: begin
        alu_res = add_w[WIDTH-1:0];
        alu_ovf = add_w[WIDTH];
      end
      OP_SUB: begin
        alu_res = sub_w[WIDTH-1:0];
        alu_ovf = sub_w[WIDTH];
      end
      OP_AND: alu_res = data1 & op_b;
      OP_OR:  alu_res = data1 | op_b;
      OP_SLL: alu_res = data1 << op_b[SHW-1:0];
      OP_SRL: alu_res = data1 >> op_b[SHW-1:0];
      OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(data1) < $signed(op_b))};
      OP_BEQ: alu_res = {{(WIDTH-1){1'b0}}, (data1 == op_b)};
      OP_BNE: alu_res = {{(WIDTH-1){1'b0}}, (data1 != op_b)};
      default: begin
        alu_res = '0;
        alu_ovf = 1'b0;
      end
    endcase
  end

`ifdef ALU_MUL_EN
  logic mul_busy;

  assign is_mul = (aluCtrl == OP_MUL);
  assign busy   = mul_busy;

  alu_mul_iter #(
    .WIDTH(WIDTH)
  ) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (accept && is_mul),
    .a       (data1),
    .b       (op_b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_prod)
  );
`else
  assign is_mul   = 1'b0;
  assign busy     = 1'b0;
  assign mul_done = 1'b0;
  assign mul_prod = '0;
`endif

  // Handshake and next-state.
  always_comb begin
    in_ready  = (state == S_IDLE) || ((state == S_VALID) && out_ready);
    accept    = in_valid && in_ready;
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          state_nxt = is_mul ? S_MUL : S_VALID;
        end
      end
      S_MUL: begin
        if (mul_done) begin
          state_nxt = S_VALID;
        end
      end
      S_VALID: begin
        // accept here implies out_ready, so the old result drains this edge.
        if (accept) begin
          state_nxt = is_mul ? S_MUL : S_VALID;
        end else if (out_ready) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    load    = (accept && !is_mul) || mul_done;
    res_nxt = mul_done ? mul_prod[WIDTH-1:0] : alu_res;
    ovf_nxt = mul_done ? (|mul_prod[2*WIDTH-1:WIDTH]) : alu_ovf;
  end

  assign out_valid = (state == S_VALID);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      result   <= '0;
      overflow <= 1'b0;
      zero     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (load) begin
        result   <= res_nxt;
        overflow <= ovf_nxt;
        zero     <= (res_nxt == '0);
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: scoreboard bench for alu_seq (32-bit and 16-bit instances).
module tb_alu_seq;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  always #5 clk = ~clk;

  // 32-bit instance signals
  logic        in_valid, in_ready, aluSrc, out_valid, out_ready, zero, overflow, busy;
  logic [31:0] data1, data2, imm, result;
  logic [3:0]  aluCtrl;

  // 16-bit instance signals
  logic        h_in_valid, h_in_ready, h_aluSrc, h_out_valid, h_out_ready;
  logic        h_zero, h_overflow, h_busy;
  logic [15:0] h_data1, h_data2, h_imm, h_result;
  logic [3:0]  h_aluCtrl;

  alu_seq #(.WIDTH(32)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .aluSrc(aluSrc),
    .data1(data1), .data2(data2), .imm(imm), .aluCtrl(aluCtrl), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .zero(zero), .overflow(overflow), .busy(busy)
  );

  alu_seq #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst(rst), .in_valid(h_in_valid), .in_ready(h_in_ready), .aluSrc(h_aluSrc),
    .data1(h_data1), .data2(h_data2), .imm(h_imm), .aluCtrl(h_aluCtrl),
    .out_valid(h_out_valid), .out_ready(h_out_ready), .result(h_result), .zero(h_zero),
    .overflow(h_overflow), .busy(h_busy)
  );

  int n_vec  = 0;
  int n_miss = 0;

  logic [33:0] exp_q[$];
  string       name_q[$];
  logic [17:0] exp16_q[$];
  string       name16_q[$];

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        src;
    logic [31:0] r;
    logic        o;
  } vec_t;

  localparam int NV = 16;
  localparam vec_t VT [NV] = '{
    '{OP_SUB, 32'd15,         32'd5,          1'b1, 32'd10,         1'b0},
    '{OP_AND, 32'hF0F0F0F1,   32'h0F0F0F0F,   1'b0, 32'h00000001,   1'b0},
    '{OP_SLT, 32'd3,          32'd5,          1'b0, 32'd1,          1'b0},
    '{OP_BNE, 32'd10,         32'd10,         1'b0, 32'd0,          1'b0},
    '{OP_OR,  32'h12340000,   32'h00005678,   1'b0, 32'h12345678,   1'b0},
    '{OP_SRL, 32'h80000000,   32'hFFFFFFE4,   1'b0, 32'h08000000,   1'b0},
    '{OP_SLL, 32'h00000003,   32'h00000021,   1'b0, 32'h00000006,   1'b0},
    '{OP_SLT, 32'hFFFFFFFF,   32'h00000001,   1'b0, 32'd1,          1'b0},
    '{OP_SLT, 32'h00000001,   32'hFFFFFFFF,   1'b0, 32'd0,          1'b0},
    '{OP_BEQ, 32'h0000ABCD,   32'h0000ABCD,   1'b0, 32'd1,          1'b0},
    '{OP_BNE, 32'd1,          32'd2,          1'b0, 32'd1,          1'b0},
    '{OP_SUB, 32'd5,          32'd15,         1'b0, 32'hFFFFFFF6,   1'b1},
    '{4'b0011, 32'd5,         32'd6,          1'b0, 32'd0,          1'b0},
    '{4'b1111, 32'hFFFFFFFF,  32'hFFFFFFFF,   1'b0, 32'd0,          1'b0},
    '{OP_ADD, 32'd1,          32'd2,          1'b1, 32'd3,          1'b0},
    '{OP_ADD, 32'h7FFFFFFF,   32'h00000001,   1'b0, 32'h80000000,   1'b0}
  };

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_miss++;
      $display("FAIL %s: got %h, want %h", nm, got, want);
    end
  endtask

  // Drive one op (called at posedge+1); returns at posedge+1 after the accepting edge.
  task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic src, input logic [31:0] er, input logic eo,
                      input string nm, output int stalls);
    logic acc;
    acc      = 1'b0;
    stalls   = 0;
    in_valid = 1'b1;
    aluCtrl  = op;
    data1    = a;
    aluSrc   = src;
    data2    = src ? ~b : b;
    imm      = src ? b : ~b;
    for (int i = 0; i < 200 && !acc; i++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      if (!acc) stalls++;
    end
    if (acc) begin
      exp_q.push_back({er, eo, (er == 32'd0)});
      name_q.push_back(nm);
    end else begin
      n_vec++;
      n_miss++;
      $display("FAIL %s_accept: in_ready got 0, want 1", nm);
    end
    #1;
  endtask

  task automatic send16(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic src, input logic [15:0] er, input logic eo,
                        input string nm);
    logic acc;
    acc        = 1'b0;
    h_in_valid = 1'b1;
    h_aluCtrl  = op;
    h_data1    = a;
    h_aluSrc   = src;
    h_data2    = src ? ~b : b;
    h_imm      = src ? b : ~b;
    for (int i = 0; i < 200 && !acc; i++) begin
      @(negedge clk);
      acc = h_in_ready;
      @(posedge clk);
    end
    if (acc) begin
      exp16_q.push_back({er, eo, (er == 16'd0)});
      name16_q.push_back(nm);
    end else begin
      n_vec++;
      n_miss++;
      $display("FAIL %s_accept: in_ready got 0, want 1", nm);
    end
    #1;
    h_in_valid = 1'b0;
  endtask

  task automatic drain(input string nm);
    for (int i = 0; i < 300 && (exp_q.size() != 0 || exp16_q.size() != 0); i++) begin
      @(negedge clk);
    end
    chk({nm, "_drained"}, exp_q.size() + exp16_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  // Monitors: pop and compare on every output transfer.
  always @(negedge clk) begin : mon32
    logic [33:0] e;
    string       nm;
    if (!rst && out_valid && out_ready) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_miss++;
        $display("FAIL unexpected_out32: got result=%h, want no output", result);
      end else begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        if ({result, overflow, zero} !== e) begin
          n_miss++;
          $display("FAIL %s: got result=%h ovf=%b zero=%b, want result=%h ovf=%b zero=%b",
                   nm, result, overflow, zero, e[33:2], e[1], e[0]);
        end
      end
    end
  end

  always @(negedge clk) begin : mon16
    logic [17:0] e;
    string       nm;
    if (!rst && h_out_valid && h_out_ready) begin
      n_vec++;
      if (exp16_q.size() == 0) begin
        n_miss++;
        $display("FAIL unexpected_out16: got result=%h, want no output", h_result);
      end else begin
        e  = exp16_q.pop_front();
        nm = name16_q.pop_front();
        if ({h_result, h_overflow, h_zero} !== e) begin
          n_miss++;
          $display("FAIL %s: got result=%h ovf=%b zero=%b, want result=%h ovf=%b zero=%b",
                   nm, h_result, h_overflow, h_zero, e[17:2], e[1], e[0]);
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1);
  end

  initial begin : stim
    int st;
    int tot;
    logic seen;
    rst = 1'b1;
    in_valid = 1'b0; out_ready = 1'b1; aluSrc = 1'b0; aluCtrl = '0;
    data1 = '0; data2 = '0; imm = '0;
    h_in_valid = 1'b0; h_out_ready = 1'b1; h_aluSrc = 1'b0; h_aluCtrl = '0;
    h_data1 = '0; h_data2 = '0; h_imm = '0;

    // Reset state
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_zero", zero, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // ADD with carry, one-cycle latency
    send(OP_ADD, 32'hFFAA123E, 32'hDD1111B1, 1'b0, 32'hDCBB23EF, 1'b1, "add_carry", st);
    in_valid = 1'b0;
    @(negedge clk);
    chk("add_latency", out_valid, 1);
    @(posedge clk);
    #1;

    // Back-to-back table, out_ready held high: no stalls allowed
    tot = 0;
    for (int i = 0; i < NV; i++) begin
      send(VT[i].op, VT[i].a, VT[i].b, VT[i].src, VT[i].r, VT[i].o,
           $sformatf("vec%0d", i), st);
      tot += st;
    end
    in_valid = 1'b0;
    chk("b2b_stalls", tot, 0);
    drain("table");

    // Backpressure: result must hold while stalled
    out_ready = 1'b0;
    send(OP_ADD, 32'd3, 32'd5, 1'b0, 32'd8, 1'b0, "bp_add", st);
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_hold_result", result, 8);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_drained_idle", out_valid, 0);
    drain("bp");

    // Multiply
`ifdef ALU_MUL_EN
    send(OP_ADD, 32'd10, 32'd20, 1'b0, 32'd30, 1'b0, "pre_mul_add", st);
    send(OP_MUL, 32'd7, 32'd9, 1'b0, 32'd63, 1'b0, "mul_7x9", st);
    in_valid = 1'b0;
    data1 = 32'hFFFFFFFF;
    data2 = 32'hFFFFFFFF;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      chk($sformatf("mul_busy_c%0d", i), busy, 1);
      chk($sformatf("mul_in_ready_c%0d", i), in_ready, 0);
    end
    @(negedge clk);
    chk("mul_latency", out_valid, 1);
    @(posedge clk);
    #1;
    send(OP_MUL, 32'h00010000, 32'h00010000, 1'b0, 32'd0, 1'b1, "mul_ovf", st);
    send(OP_MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'd1, 1'b1, "mul_max", st);
    in_valid = 1'b0;
    drain("mul");
`else
    send(OP_MUL, 32'd7, 32'd9, 1'b0, 32'd0, 1'b0, "mul_disabled", st);
    in_valid = 1'b0;
    @(negedge clk);
    chk("mul_disabled_busy", busy, 0);
    chk("mul_disabled_latency", out_valid, 1);
    @(posedge clk);
    #1;
    drain("mul_disabled");
`endif

    // Asynchronous reset with work in flight
`ifdef ALU_MUL_EN
    send(OP_MUL, 32'd7, 32'd9, 1'b0, 32'd63, 1'b0, "rst_mul", st);
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
`else
    out_ready = 1'b0;
    send(OP_ADD, 32'hFFFFFFFF, 32'd2, 1'b0, 32'd1, 1'b1, "rst_add", st);
    in_valid = 1'b0;
    @(negedge clk);
    chk("rst_pre_valid", out_valid, 1);
    @(posedge clk);
    #1;
`endif
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_result", result, 0);
    chk("midrst_overflow", overflow, 0);
    chk("midrst_zero", zero, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_in_ready", in_ready, 1);
    exp_q.delete();
    name_q.delete();
    out_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      seen |= out_valid;
    end
    chk("postrst_no_stale_valid", seen, 0);
    @(posedge clk);
    #1;
    send(OP_ADD, 32'd1, 32'd1, 1'b0, 32'd2, 1'b0, "postrst_add", st);
    in_valid = 1'b0;
    drain("postrst");

    // 16-bit instance
    send16(OP_SLL, 16'd1, 16'h0013, 1'b0, 16'd8, 1'b0, "w16_sll");
    send16(OP_ADD, 16'hFFFF, 16'h0001, 1'b1, 16'h0000, 1'b1, "w16_add_carry");
    send16(OP_SUB, 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, "w16_sub_borrow");
`ifdef ALU_MUL_EN
    send16(OP_MUL, 16'h0100, 16'h0100, 1'b0, 16'h0000, 1'b1, "w16_mul_ovf");
    send16(OP_MUL, 16'h00FF, 16'h0003, 1'b0, 16'h02FD, 1'b0, "w16_mul");
`else
    send16(OP_MUL, 16'h0100, 16'h0100, 1'b0, 16'h0000, 1'b0, "w16_mul_disabled");
`endif
    drain("w16");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Registered, handshaked, parametrised successor to the combinational 32-bit MIPS ALU.
- Keeps the existing operation encoding and operand-select behaviour.
- Adds a valid/ready interface on both sides, a parametrised datapath width, and an iterative multi-cycle multiply.
- Sits between the decode stage and writeback; the output register isolates ALU timing from the downstream stage.

Parameters:
WIDTH, 32, datapath width in bits (>=8, power of two)
SHW, $clog2(WIDTH), shift-amount width (derived, not overridden)

Ports:
clk  in  1  single system clock, rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  operation presented
in_ready  out  1  block can accept an operation this cycle
aluSrc  in  1  0: operand B = data2; 1: operand B = imm
data1  in  WIDTH  operand A
data2  in  WIDTH  register operand B
imm  in  WIDTH  immediate operand B (already extended)
aluCtrl  in  4  operation select
out_valid  out  1  result registers hold a valid result
out_ready  in  1  downstream consumes result
result  out  WIDTH  operation result
zero  out  1  result == 0
overflow  out  1  per-op flag, defined below
busy  out  1  multiply iteration in progress

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous, active-high.
- Reset values: out_valid=0, result=0, zero=0, overflow=0, busy=0, state=S_IDLE, iteration counter=0.
- Transfer rules:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
  - result, zero and overflow are stable while out_valid && !out_ready.
- Operation encodings:
  - 0000 ADD: overflow = unsigned carry out of the MSB.
  - 0010 SUB: overflow = borrow (A < B unsigned).
  - 0100 AND, 0101 OR.
  - 0110 SLL, 0111 SRL: shift A by B[SHW-1:0].
  - 1000 SLT: signed; result 1/0.
  - 1001 BEQ: result = (A==B).
  - 1010 BNE: result = (A!=B).
  - 1011 MUL: see below.
  - All other encodings: result 0, overflow 0.
  - overflow = 0 for every op not listed with an overflow rule.
- Arithmetic: operands and result are WIDTH bits; ADD/SUB are evaluated at WIDTH+1 bits to extract carry/borrow. zero is derived from the registered result.
- FSM states:
  - S_IDLE: output empty.
    - Single-cycle op accepted → S_VALID.
    - MUL accepted → S_MUL.
  - S_MUL: shift-add over exactly WIDTH cycles using a counter; busy=1, in_ready=0. When counter reaches WIDTH-1 → S_VALID.
  - S_VALID: output full.
    - out_ready with no new accept → S_IDLE.
    - out_ready with a simultaneous single-cycle accept → stay S_VALID, new result loaded.
    - out_ready with a simultaneous MUL accept → S_MUL (out_valid drops).
- in_ready = (state==S_IDLE) || (state==S_VALID && out_ready).
- Latency:
  - Single-cycle op accepted at edge N → out_valid at edge N (visible the following cycle).
  - MUL accepted at edge N → out_valid after edge N+WIDTH.
- Throughput: one single-cycle op per clock with out_ready held high.
- MUL: result = low WIDTH bits of the unsigned product; overflow = 1 if the high WIDTH bits are non-zero.
- Reset mid-MUL: the partial product is discarded immediately; no stale out_valid after rst deasserts.
- Inputs are sampled only on accept; changes while busy are ignored.

Optional Feature:
ALU_MUL_EN
- Defined: MUL (1011) is implemented as above.
- Undefined: MUL logic and S_MUL are removed; 1011 behaves as an unused encoding (result 0, overflow 0, single-cycle); busy is tied 0.

Decomposition:
- Package alu_pkg:
  - Op-code localparams: OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLL, OP_SRL, OP_SLT, OP_BEQ, OP_BNE, OP_MUL.
  - FSM state encodings: S_IDLE, S_MUL, S_VALID.
- Sub-module: alu_mul_iter (WIDTH-parametrised shift-add multiplier with start/done, 2*WIDTH product), instantiated under ALU_MUL_EN.
- Single-cycle datapath stays in alu_seq.

Test Plan:
1. WIDTH=32, ADD 0xFFAA123E + 0xDD1111B1, out_ready=1 → result 0xDCBB23EF, overflow=1, zero=0, one cycle after accept.
2. Back-to-back SUB 15-5, AND 0xF0F0F0F1&0x0F0F0F0F, SLT 3<5, BNE 10!=10 with out_ready=1 → results 10, 0x00000001, 1, 0 (zero=1) on consecutive cycles; in_ready stays 1.
3. Backpressure: ADD 3+5 with out_ready=0 for 4 cycles → result holds 8, in_ready=0, then drains on out_ready=1.
4. ALU_MUL_EN, MUL 7*9 → busy=1 and in_ready=0 for 32 cycles, then result 63, overflow 0. MUL 0x00010000*0x00010000 → result 0, overflow 1, zero 1.
5. rst asserted at MUL cycle 10 → all outputs 0 and state S_IDLE immediately. Next ADD 1+1 → 2.
6. WIDTH=16, SLL 1 by data2=0x13 (shift amount uses low 4 bits = 3) → result 8. ADD 0xFFFF+1 → 0, overflow 1.
